// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and byte geometry.
package i2c_slave_pkg;

    localparam int unsigned BitCount = 8;
    // Value of the 3-bit bit counter while the last bit of a byte is being sampled.
    localparam logic [2:0] LastBit = 3'(BitCount - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StWaitStop
    } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one I2C line, with edge detection.
// Ports:
//   clk, reset  system clock, async active-high reset (flops reset to 1 = idle bus)
//   line        raw pad value
//   level       synchronized level
//   rise, fall  one-cycle strobes on synchronized rising / falling edges
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= line;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target (no clock stretching, always ACKs written bytes).
// Ports:
//   clk, reset   system clock, async active-high reset
//   i_scl, i_sda pad values of SCL/SDA
//   o_sda        open-drain control: 1 = release, 0 = pull low
//   i_tx_data    byte returned on reads; latched when o_rd_req pulses
//   o_rd_req     pulse: i_tx_data latched, next byte may be presented
//   o_rx_data    last byte written by the master; o_rx_valid pulses on update
//   o_start      pulse on START / repeated START; o_stop pulse on STOP
//   o_busy       high from address match until STOP or a non-matching START
//   o_rw         R/W bit of the last matched address (1 = master read)
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    input  logic [7:0] i_tx_data,
    output logic       o_rd_req,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    output logic       o_rw
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    // Last bit of the current byte seen; the ACK phase starts at the next SCL fall.
    logic       done_q, done_d;
    logic       sda_q, sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d, busy_q, busy_d;
    logic       start_q, start_d, stop_q, stop_d;
    logic       rx_valid_q, rx_valid_d, rd_req_q, rd_req_d;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .line  (i_scl),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .line  (i_sda),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;

        if (start_det) begin
            // Bus conditions win over any bit handling in the same cycle.
            start_d   = 1'b1;
            state_d   = StAddr;
            bit_cnt_d = '0;
            done_d    = 1'b0;
            sda_d     = 1'b1;
        end else if (stop_det) begin
            stop_d  = 1'b1;
            state_d = StIdle;
            done_d  = 1'b0;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastBit) begin
                            // shift_q[6:0] already holds the 7 address bits.
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                rw_d   = sda;
                                busy_d = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b0;
                                sda_d   = 1'b1;
                                state_d = StWaitStop;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        sda_d   = 1'b0;
                        state_d = StAddrAck;
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            shift_d  = i_tx_data;
                            rd_req_d = 1'b1;
                            sda_d    = i_tx_data[7];
                            state_d  = StRead;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastBit) begin
                            rx_data_d  = {shift_q[6:0], sda};
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        sda_d   = 1'b0;
                        state_d = StWriteAck;
                    end
                end
                StWriteAck: begin
                    if (scl_fall) begin
                        sda_d   = 1'b1;
                        state_d = StWrite;
                    end
                end
                StRead: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastBit) begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d  = 1'b0;
                            sda_d   = 1'b1;
                            state_d = StReadAck;
                        end else begin
                            // MSB went out when the byte was loaded; shift the next one on.
                            shift_d = {shift_q[6:0], 1'b0};
                            sda_d   = shift_q[6];
                        end
                    end
                end
                StReadAck: begin
                    if (scl_rise && sda) begin
                        state_d = StWaitStop;
                    end else if (scl_fall) begin
                        // Only reachable after an ACK rise: the state is entered on a fall.
                        bit_cnt_d = '0;
                        shift_d   = i_tx_data;
                        rd_req_d  = 1'b1;
                        sda_d     = i_tx_data[7];
                        state_d   = StRead;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            sda_q      <= 1'b1;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rx_valid_q <= rx_valid_d;
            rd_req_q   <= rd_req_d;
        end
    end

    assign o_sda      = sda_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rd_req   = rd_req_q;
    assign o_start    = start_q;
    assign o_stop     = stop_q;
    assign o_busy     = busy_q;
    assign o_rw       = rw_q;

endmodule
